// File: rtl/sys_bus_ctrl.sv
// System-bus controller: decodes CPU requests to a small VDP register window or
// to external RAM with programmable wait states, and keeps a read-cleared IRQ flag.
module sys_bus_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] IO_BASE      = 'hFFF0,
  parameter int                IO_SIZE_LOG2 = 4,
  parameter int                NUM_REGS     = 8,
  parameter int                STATUS_IDX   = 7,
  parameter int                RAM_WAIT     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_we,
  input  logic                       cpu_req,
  output logic                       cpu_ready,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  output logic                       ram_cs,
  output logic                       ram_we,
  input  logic [DATA_W-1:0]          ram_rdata,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        reg_wr,
  input  logic [DATA_W-1:0]          status_in,
  input  logic                       irq_set,
  output logic                       irq
);

  localparam int IW = IO_SIZE_LOG2;
  localparam logic [IW-1:0] SIDX = STATUS_IDX[IW-1:0];
  localparam logic [3:0]    WAIT = RAM_WAIT[3:0];

  typedef enum logic [1:0] {IDLE, RAM_ACC, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                ram_cs_q, ram_cs_d;
  logic                ram_we_q, ram_we_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic                irq_q, irq_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                io_hit;
  logic [IW-1:0]       idx;
  logic [DATA_W-1:0]   reg_rd;
  logic                status_rd;
  logic                unused_status_msb;

  assign io_hit            = cpu_addr[ADDR_W-1:IW] == IO_BASE[ADDR_W-1:IW];
  assign idx               = cpu_addr[IW-1:0];
  // The top status bit is replaced by the pending IRQ flag on reads.
  assign unused_status_msb = status_in[DATA_W-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_cs_d    = ram_cs_q;
    ram_we_d    = ram_we_q;
    reg_wr_d    = '0;
    regs_d      = regs_q;
    status_rd   = 1'b0;

    // Unimplemented indices fall through with reg_rd = 0.
    reg_rd = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IW'(i)) reg_rd = regs_q[i];
    end

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (io_hit) begin
            state_d = RESP;
            ready_d = 1'b1;
            if (cpu_we) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IW'(i) && i != STATUS_IDX) begin
                  regs_d[i]   = cpu_wdata;
                  reg_wr_d[i] = 1'b1;
                end
              end
            end else if (idx == SIDX) begin
              rdata_d   = {irq_q, status_in[DATA_W-2:0]};
              status_rd = 1'b1;
            end else begin
              rdata_d = reg_rd;
            end
          end else begin
            state_d     = RAM_ACC;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            ram_we_d    = cpu_we;
            ram_cs_d    = 1'b1;
            cnt_d       = WAIT;
          end
        end
      end
      RAM_ACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!ram_we_q) rdata_d = ram_rdata;
          ram_cs_d = 1'b0;
          ram_we_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A coincident event wins over the read-clear.
    irq_d = irq_set | (irq_q & ~status_rd);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      reg_wr_q    <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      reg_wr_q    <= reg_wr_d;
      irq_q       <= irq_d;
      regs_q      <= regs_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      if (gi == STATUS_IDX) begin : g_status
        assign reg_out[gi*DATA_W +: DATA_W] = '0;
      end else begin : g_plain
        assign reg_out[gi*DATA_W +: DATA_W] = regs_q[gi];
      end
    end
  endgenerate

  assign cpu_ready = ready_q;
  assign cpu_rdata = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign reg_wr    = reg_wr_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// Directed bench for sys_bus_ctrl: a transaction-level model predicts every
// output cycle by cycle, and literal expectations pin the model down.
module tb_sys_bus_ctrl;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we, cpu_req;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_cs, ram_we;
  logic [7:0]  ram_rdata;
  logic [63:0] reg_out;
  logic [7:0]  reg_wr;
  logic [7:0]  status_in;
  logic        irq_set, irq;

  // Second instance with zero wait states, driven separately.
  logic [15:0] b_addr;
  logic        b_req, b_ready, b_cs, b_we, b_irq;
  logic [7:0]  b_rdata, b_ram_rdata, b_ram_wdata, b_reg_wr;
  logic [15:0] b_ram_addr;
  logic [63:0] b_reg_out;

  always #5 clk = ~clk;

  sys_bus_ctrl #(.RAM_WAIT(W)) u_dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .reg_out(reg_out), .reg_wr(reg_wr), .status_in(status_in),
    .irq_set(irq_set), .irq(irq));

  sys_bus_ctrl #(.RAM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_addr(b_addr), .cpu_wdata(8'h00),
    .cpu_we(1'b0), .cpu_req(b_req), .cpu_ready(b_ready), .cpu_rdata(b_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_cs(b_cs), .ram_we(b_we),
    .ram_rdata(b_ram_rdata), .reg_out(b_reg_out), .reg_wr(b_reg_wr), .status_in(status_in),
    .irq_set(irq_set), .irq(b_irq));

  int n_pass = 0;
  int n_tot  = 0;
  int rdy_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level model: edge count, one outstanding transaction, register image.
  int          cyc, start, lat_m;
  bit          busy, m_ram, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata, m_strobe;
  logic        m_irq;
  logic [7:0]  m_regs [8];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; busy = 0; m_rdata = 0; m_irq = 0; m_strobe = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    end else begin
      bit st_rd;
      int idx;
      st_rd = 0;
      cyc++;
      if (busy) begin
        if (m_ram && !m_we && cyc == start + 1 + W) m_rdata = ram_rdata;
        if (cyc == start + lat_m) busy = 0;
      end else if (cpu_req) begin
        start = cyc; busy = 1;
        m_addr = cpu_addr; m_we = cpu_we; m_wdata = cpu_wdata;
        m_ram = (cpu_addr < 16'hFFF0);
        m_strobe = 0;
        lat_m = m_ram ? 2 + W : 1;
        if (!m_ram) begin
          idx = int'(cpu_addr - 16'hFFF0);
          if (cpu_we) begin
            if (idx < 8 && idx != 7) begin
              m_regs[idx] = cpu_wdata;
              m_strobe = 8'(1 << idx);
            end
          end else if (idx == 7) begin
            m_rdata = {m_irq, status_in[6:0]};
            st_rd = 1;
          end else if (idx < 8) m_rdata = m_regs[idx];
          else m_rdata = 8'h00;
        end
      end
      if (irq_set) m_irq = 1'b1;
      else if (st_rd) m_irq = 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      int k;
      bit e_rdy, e_cs;
      logic [63:0] e_regs;
      k = busy ? (cyc - start + 1) : 0;
      e_rdy = busy && (k == lat_m);
      e_cs  = busy && m_ram && (k >= 1) && (k <= 1 + W);
      for (int i = 0; i < 8; i++) e_regs[i*8 +: 8] = m_regs[i];
      if (cpu_ready) rdy_cnt++;
      chk("cpu_ready", 64'(cpu_ready), 64'(e_rdy));
      chk("ram_cs", 64'(ram_cs), 64'(e_cs));
      chk("ram_we", 64'(ram_we), 64'(e_cs && m_we));
      if (e_cs) chk("ram_addr", 64'(ram_addr), 64'(m_addr));
      if (e_cs && m_we) chk("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
      chk("reg_wr", 64'(reg_wr),
          64'((busy && !m_ram && m_we && k == 1) ? m_strobe : 8'h00));
      chk("irq", 64'(irq), 64'(m_irq));
      chk("cpu_rdata", 64'(cpu_rdata), 64'(m_rdata));
      chk("reg_out", reg_out, e_regs);
    end
  end

  // Issue one request at posedge+1 and hold it until cpu_ready; returns latency in cycles.
  task automatic issue(input logic [15:0] a, input logic we, input logic [7:0] wd,
                       input bit pulse, output logic [7:0] rd, output int lat,
                       output logic [7:0] wr_seen);
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
    if (pulse) irq_set = 1'b1;
    lat = -1; wr_seen = 8'h00; rd = 8'hxx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pulse && n >= 1) irq_set = 1'b0;
      wr_seen |= reg_wr;
      if (cpu_ready) begin
        lat = n; rd = cpu_rdata;
        break;
      end
    end
    if (lat < 0) chk("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    $display("txn addr=%04h we=%0d wdata=%02h rdata=%02h lat=%0d strobe=%02h",
             a, we, wd, rd, lat, wr_seen);
  endtask

  initial begin
    logic [7:0]  rd, ws;
    int          lat, c0, n;
    logic [63:0] snap;
    reset = 1'b1; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_req = 0;
    ram_rdata = 0; status_in = 0; irq_set = 0;
    b_addr = 0; b_req = 0; b_ram_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(cpu_ready), 64'd0);
    chk("rst_cs", 64'(ram_cs), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_regs", reg_out, 64'd0);
    chk("rst_rdata", 64'(cpu_rdata), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // Register write then read back.
    issue(16'hFFF2, 1'b1, 8'hA5, 0, rd, lat, ws);
    chk("wr_lat", 64'(lat), 64'd1);
    chk("wr_strobe", 64'(ws), 64'h04);
    chk("wr_regout", 64'(reg_out[23:16]), 64'hA5);
    issue(16'hFFF2, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("rd_data", 64'(rd), 64'hA5);
    chk("rd_lat", 64'(lat), 64'd1);

    // RAM read with one wait state.
    ram_rdata = 8'h3C;
    issue(16'h1234, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("ram_lat", 64'(lat), 64'd3);
    chk("ram_data", 64'(rd), 64'h3C);

    // IRQ set then status read clears it.
    status_in = 8'h15;
    irq_set = 1'b1; @(posedge clk); #1; irq_set = 1'b0;
    issue(16'hFFF7, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("stat_data", 64'(rd), 64'h95);
    chk("stat_irq_clr", 64'(irq), 64'd0);
    // Coincident set with the status read keeps irq.
    irq_set = 1'b1; @(posedge clk); #1; irq_set = 1'b0;
    issue(16'hFFF7, 1'b0, 8'h00, 1, rd, lat, ws);
    chk("stat_coinc_data", 64'(rd), 64'h95);
    chk("stat_coinc_irq", 64'(irq), 64'd1);
    issue(16'hFFF7, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("stat_clr2", 64'(irq), 64'd0);

    // Ignored writes.
    snap = reg_out;
    issue(16'hFFF7, 1'b1, 8'h77, 0, rd, lat, ws);
    chk("wr_status_strobe", 64'(ws), 64'h00);
    chk("wr_status_lat", 64'(lat), 64'd1);
    issue(16'hFFFC, 1'b1, 8'h77, 0, rd, lat, ws);
    chk("wr_unimpl_strobe", 64'(ws), 64'h00);
    chk("wr_ignored_regs", reg_out, snap);
    issue(16'hFFFC, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("rd_unimpl", 64'(rd), 64'h00);

    // Back-to-back I/O write then RAM write.
    c0 = rdy_cnt;
    issue(16'hFFF3, 1'b1, 8'h5A, 0, rd, lat, ws);
    issue(16'h0010, 1'b1, 8'hC3, 0, rd, lat, ws);
    chk("b2b_ram_lat", 64'(lat), 64'd3);
    chk("b2b_regout", 64'(reg_out[31:24]), 64'h5A);
    @(negedge clk);
    chk("b2b_ready_cnt", 64'(rdy_cnt - c0), 64'd2);
    @(posedge clk); #1;

    // Reset during the second ram_cs cycle.
    ram_rdata = 8'h00;
    cpu_addr = 16'h2000; cpu_we = 1'b0; cpu_req = 1'b1;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_cs", 64'(ram_cs), 64'd1);
    reset = 1'b1; #1;
    chk("rst_mid_cs", 64'(ram_cs), 64'd0);
    chk("rst_mid_ready", 64'(cpu_ready), 64'd0);
    cpu_req = 1'b0;
    @(negedge clk); reset = 1'b0;
    c0 = rdy_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_ready", 64'(rdy_cnt - c0), 64'd0);
    issue(16'hFFF2, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("post_rst_reg", 64'(rd), 64'h00);
    ram_rdata = 8'h3C;
    issue(16'h1234, 1'b0, 8'h00, 0, rd, lat, ws);
    chk("post_rst_ram", 64'(rd), 64'h3C);
    chk("post_rst_lat", 64'(lat), 64'd3);

    // Zero wait-state instance: ready in cycle 2, chip select for one cycle.
    b_ram_rdata = 8'h3C; b_addr = 16'h1234; b_req = 1'b1;
    lat = -1; c0 = 0;
    for (n = 0; n < 10; n++) begin
      @(negedge clk);
      if (b_cs) c0++;
      if (b_ready) begin lat = n; break; end
    end
    chk("w0_lat", 64'(lat), 64'd2);
    chk("w0_data", 64'(b_rdata), 64'h3C);
    chk("w0_cs_cycles", 64'(c0), 64'd1);
    $display("txn w0 addr=1234 rdata=%02h lat=%0d", b_rdata, lat);
    @(posedge clk); #1; b_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
